param_cache: RTL and testbench
==============================

# param_cache

Parametrised direct-mapped, write-through, write-no-allocate cache with its controller built in. It sits between the CPU load/store port and a word-serial data memory. It hides memory latency behind `Stall`, and refills a whole line one word per memory beat. Address width, word width, line size and line count are all set by parameters. Memory latency is variable and handled by a per-beat ready handshake rather than a fixed counter.

## Interface
- `ADDR_W`, 10, CPU word-address width.
- `DATA_W`, 32, word width.
- `WORDS_PER_LINE`, 4, words per line; power of two, ≥2.
- `LINES`, 32, number of lines; power of two.
- Address split: `OFF_W = clog2(WORDS_PER_LINE)`, `IDX_W = clog2(LINES)`, `TAG_W = ADDR_W − IDX_W − OFF_W`. Defaults give tag [9:7], index [6:2], offset [1:0].
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `MemReadCpu` in 1: CPU read request, held until `Stall` is 0.
- `MemWriteCpu` in 1: CPU write request, held until `Stall` is 0.
- `Address` in `ADDR_W`: CPU word address.
- `DataIn` in `DATA_W`: CPU write data.
- `Stall` out 1: CPU must hold its request.
- `DataOut` out `DATA_W`: read data; valid when `MemReadCpu & !Stall`.
- `MemRead` out 1: memory read strobe, one beat per `MemReady`.
- `MemWrite` out 1: memory write strobe.
- `MemAddress` out `ADDR_W`: memory word address.
- `MemDataOut` out `DATA_W`: write data to memory.
- `MemDataIn` in `DATA_W`: read data from memory, sampled when `MemReady` is 1.
- `MemReady` in 1: current memory beat completes this cycle.

## Operation
- FSM states: `IDLE`, `FILL`, `WRITE`, `DONE`.
- **IDLE**
  - Write request (wins if both requests are set): `Stall` = 1, go to `WRITE`.
  - Read hit (`valid[idx]` and tag match): `Stall` = 0, `DataOut` = line word at offset, combinational, stay in `IDLE`.
  - Read miss: `Stall` = 1, latch line base, clear beat counter, go to `FILL`.
  - No request: `Stall` = 0, `DataOut` = 0.
- **FILL**
  - `Stall` = 1, `MemRead` = 1, `MemAddress` = {tag, idx, beat}.
  - Each `MemReady` writes `MemDataIn` into word `beat` and increments `beat`.
  - On the last beat (`beat` = `WORDS_PER_LINE−1`): write the tag, set valid, go to `IDLE`. The held read then hits.
- **WRITE**
  - `Stall` = 1, `MemWrite` = 1, `MemAddress` = `Address`, `MemDataOut` = `DataIn`.
  - On `MemReady`: if the line hits, update that word in the cache. Then go to `DONE`.
  - A write miss does not allocate; valid and tag are unchanged.
- **DONE**: `Stall` = 0 for exactly one cycle (the write retires), then go to `IDLE` unconditionally. The request is not re-evaluated in `DONE`.
- `MemRead` and `MemWrite` are never 1 in the same cycle.
- The beat counter is `OFF_W` bits wide and wraps to 0 after the last beat.

## Timing
- Reset (`RST` = 0, takes effect at once, including mid-`FILL` or mid-`WRITE`):
  - FSM goes to `IDLE`; all valid bits are cleared; beat counter = 0.
  - `Stall`, `MemRead`, `MemWrite` = 0; `MemAddress`, `MemDataOut`, `DataOut` = 0.
  - Tag and data arrays are not cleared.
- Read hit: 0 stall cycles.
- Read miss with `MemReady` held at 1: `WORDS_PER_LINE`+1 stall cycles (5 by default). Data is returned in the following cycle.
- Write with `MemReady` held at 1: 2 stall cycles, then 1 cycle of `DONE`.
- `MemReady` may stay low indefinitely. Strobes and address stay stable until a beat completes.
- `MemReady` is ignored in `IDLE` and `DONE`.

## Configuration
- Macro: `CACHE_STATS_EN`.
- When defined, the block adds two output ports:
  - `HitCount` out 16: saturating count of reads that hit in `IDLE`, excluding the retiring cycle right after a `FILL`.
  - `MissCount` out 16: saturating count of read-miss detections.
  - Both counters reset to 0.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `cache_pkg` holds:
  - the state enum (`IDLE`, `FILL`, `WRITE`, `DONE`);
  - the `clog2`-derived width localparams and the tag/index/offset extract functions;
  - `STAT_W` = 16.
- Sub-module `cache_line_store` holds the valid/tag/data arrays:
  - one read port, combinational by index;
  - word write port (fill beat and write hit);
  - tag/valid write;
  - asynchronous clear of valid.

## Test plan
- **Cold read miss:** after reset, read 0x000 with `MemReady` = 1 → `Stall` = 1 for 5 cycles; `MemAddress` = 0x000–0x003; then `Stall` = 0 and `DataOut` = mem[0x000].
- **Read hit:** read 0x003 next → `Stall` = 0 in the same cycle, `DataOut` = mem[0x003], no memory strobe.
- **Write hit:** write 0x002 with 0xDEADBEEF → `MemWrite` = 1 with `MemAddress` = 0x002, `Stall` = 0 in `DONE`. A later read of 0x002 returns 0xDEADBEEF with no stall.
- **Conflict eviction:** read 0x080 (index 0, tag 1) → miss and refill; re-reading 0x000 then misses. With `CACHE_STATS_EN`, `MissCount` = 3 and `HitCount` = 2.
- **Write miss:** write 0x100 → memory is written, no allocation; a following read of 0x100 misses.
- **Reset mid-fill:** assert `RST` after 2 fill beats → `MemRead` and `Stall` drop at once; after release, read 0x000 misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, default geometry and address-field helpers for param_cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  localparam int unsigned STAT_W      = 16;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_WPL     = 4;
  localparam int unsigned DEF_LINES   = 32;
  localparam int unsigned DEF_OFF_W   = $clog2(DEF_WPL);
  localparam int unsigned DEF_IDX_W   = $clog2(DEF_LINES);
  localparam int unsigned DEF_TAG_W   = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;

  // Field extractors work on a zero-extended 32-bit word address; callers truncate.
  function automatic logic [31:0] addr_off(logic [31:0] a, int unsigned off_w);
    return a & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(logic [31:0] a, int unsigned off_w,
                                           int unsigned idx_w);
    return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(logic [31:0] a, int unsigned off_w,
                                           int unsigned idx_w);
    return a >> (off_w + idx_w);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for param_cache: combinational read by index, word and tag writes,
// asynchronous clear of the valid bits only.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned WORDS_PER_LINE = DEF_WPL,
  parameter int unsigned LINES          = DEF_LINES,
  parameter int unsigned OFF_W          = DEF_OFF_W,
  parameter int unsigned IDX_W          = DEF_IDX_W,
  parameter int unsigned TAG_W          = DEF_TAG_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [IDX_W-1:0]                       rd_idx,
  output logic                                   rd_valid,
  output logic [TAG_W-1:0]                       rd_tag,
  output logic [WORDS_PER_LINE-1:0][DATA_W-1:0]  rd_line,
  input  logic                                   wr_en,
  input  logic [IDX_W-1:0]                       wr_idx,
  input  logic [OFF_W-1:0]                       wr_off,
  input  logic [DATA_W-1:0]                      wr_data,
  input  logic                                   tv_en,
  input  logic [IDX_W-1:0]                       tv_idx,
  input  logic [TAG_W-1:0]                       tv_tag
);

  logic [LINES-1:0]                       valid_q;
  logic [TAG_W-1:0]                       tag_q  [LINES];
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]  data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (tv_en) begin
      valid_q[tv_idx] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (tv_en) tag_q[tv_idx] <= tv_tag;
    if (wr_en) data_q[wr_idx][wr_off] <= wr_data;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/param_cache.sv
// Direct-mapped write-through, write-no-allocate cache with built-in controller.
// Define CACHE_STATS_EN to add saturating HitCount/MissCount outputs.
module param_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned WORDS_PER_LINE = DEF_WPL,
  parameter int unsigned LINES          = DEF_LINES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemReadCpu,
  input  logic              MemWriteCpu,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic              Stall,
  output logic [DATA_W-1:0] DataOut,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataOut,
  input  logic [DATA_W-1:0] MemDataIn,
  input  logic              MemReady
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0] HitCount,
  output logic [STAT_W-1:0] MissCount
`endif
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

  state_e            state_q;
  logic [OFF_W-1:0]  beat_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic              fill_done_q;

  logic [OFF_W-1:0]  a_off;
  logic [IDX_W-1:0]  a_idx;
  logic [TAG_W-1:0]  a_tag;

  logic                                  rd_valid;
  logic [TAG_W-1:0]                      rd_tag;
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0] rd_line;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [OFF_W-1:0]  wr_off;
  logic [DATA_W-1:0] wr_data;
  logic              tv_en;

  logic hit;
  logic rd_req;
  logic last_beat;

  assign a_off = OFF_W'(addr_off(32'(Address), OFF_W));
  assign a_idx = IDX_W'(addr_idx(32'(Address), OFF_W, IDX_W));
  assign a_tag = TAG_W'(addr_tag(32'(Address), OFF_W, IDX_W));

  assign hit       = rd_valid && (rd_tag == a_tag);
  assign rd_req    = MemReadCpu && !MemWriteCpu;
  assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));

  cache_line_store #(
    .DATA_W         (DATA_W),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .LINES          (LINES),
    .OFF_W          (OFF_W),
    .IDX_W          (IDX_W),
    .TAG_W          (TAG_W)
  ) u_store (
    .clk      (CLK),
    .rst_n    (RST),
    .rd_idx   (a_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_off   (wr_off),
    .wr_data  (wr_data),
    .tv_en    (tv_en),
    .tv_idx   (fill_idx_q),
    .tv_tag   (fill_tag_q)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      fill_tag_q  <= '0;
      fill_idx_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (MemWriteCpu) begin
            state_q <= WRITE;
          end else if (MemReadCpu && !hit) begin
            fill_tag_q <= a_tag;
            fill_idx_q <= a_idx;
            beat_q     <= '0;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (MemReady) begin
            beat_q <= beat_q + OFF_W'(1);
            if (last_beat) begin
              state_q     <= IDLE;
              fill_done_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (MemReady) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state; reset forces them low immediately.
  always_comb begin
    Stall      = 1'b0;
    DataOut    = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemAddress = '0;
    MemDataOut = '0;
    if (RST) begin
      unique case (state_q)
        IDLE: begin
          if (MemWriteCpu) begin
            Stall = 1'b1;
          end else if (MemReadCpu) begin
            if (hit) DataOut = rd_line[a_off];
            else     Stall   = 1'b1;
          end
        end
        FILL: begin
          Stall      = 1'b1;
          MemRead    = 1'b1;
          MemAddress = {fill_tag_q, fill_idx_q, beat_q};
        end
        WRITE: begin
          Stall      = 1'b1;
          MemWrite   = 1'b1;
          MemAddress = Address;
          MemDataOut = DataIn;
        end
        DONE: ;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = a_idx;
    wr_off  = a_off;
    wr_data = DataIn;
    tv_en   = 1'b0;
    if (state_q == FILL && MemReady) begin
      wr_en   = 1'b1;
      wr_idx  = fill_idx_q;
      wr_off  = beat_q;
      wr_data = MemDataIn;
      tv_en   = last_beat;
    end else if (state_q == WRITE && MemReady && hit) begin
      wr_en = 1'b1;
    end
  end

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;
  logic              count_hit;
  logic              count_miss;

  // The hit right after a fill is the retiring miss, not a fresh hit.
  assign count_hit  = (state_q == IDLE) && rd_req && hit && !fill_done_q;
  assign count_miss = (state_q == IDLE) && rd_req && !hit;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (count_hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + STAT_W'(1);
      if (count_miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + STAT_W'(1);
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_param_cache.sv
// Directed bench for param_cache with a word memory model and an expected-data scoreboard.
module tb_param_cache;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MemReadCpu = 1'b0;
  logic        MemWriteCpu = 1'b0;
  logic [9:0]  Address = '0;
  logic [31:0] DataIn = '0;
  logic        Stall;
  logic [31:0] DataOut;
  logic        MemRead;
  logic        MemWrite;
  logic [9:0]  MemAddress;
  logic [31:0] MemDataOut;
  logic [31:0] MemDataIn;
  logic        MemReady = 1'b1;
`ifdef CACHE_STATS_EN
  logic [15:0] HitCount;
  logic [15:0] MissCount;
`endif

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_q   [$];
  bit          ready_rand = 1'b0;
  int          vectors = 0;
  int          misses  = 0;

  param_cache dut (
    .CLK         (CLK),
    .RST         (RST),
    .MemReadCpu  (MemReadCpu),
    .MemWriteCpu (MemWriteCpu),
    .Address     (Address),
    .DataIn      (DataIn),
    .Stall       (Stall),
    .DataOut     (DataOut),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemAddress  (MemAddress),
    .MemDataOut  (MemDataOut),
    .MemDataIn   (MemDataIn),
    .MemReady    (MemReady)
`ifdef CACHE_STATS_EN
    ,
    .HitCount    (HitCount),
    .MissCount   (MissCount)
`endif
  );

  always #5 CLK = ~CLK;

  assign MemDataIn = mem[MemAddress];

  always @(posedge CLK) begin
    if (RST && MemWrite && MemReady) mem[MemAddress] <= MemDataOut;
  end

  always @(posedge CLK) begin
    #1 MemReady = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that retires the read.
  task automatic do_read(input logic [9:0] a, input int exp_stall, input string tag);
    int n = 0;
    int beat = 0;
    exp_q.push_back(ref_mem[a]);
    MemReadCpu = 1'b1;
    Address    = a;
    @(negedge CLK);
    while (Stall && n < 200) begin
      chk({tag, "_excl"}, 32'(MemRead & MemWrite), 32'd0);
      if (MemRead) begin
        chk({tag, "_fill_addr"}, 32'(MemAddress), 32'({a[9:2], 2'b00}) + 32'(beat));
        if (MemReady) beat++;
      end
      n++;
      @(negedge CLK);
    end
    if (exp_stall >= 0) chk({tag, "_stalls"}, 32'(n), 32'(exp_stall));
    else                chk({tag, "_bounded"}, 32'(Stall), 32'd0);
    chk({tag, "_idle_strobes"}, 32'({MemRead, MemWrite}), 32'd0);
    chk({tag, "_data"}, DataOut, exp_q.pop_front());
    @(posedge CLK);
    #1 MemReadCpu = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int exp_stall,
                          input string tag);
    int n = 0;
    ref_mem[a]  = d;
    MemWriteCpu = 1'b1;
    Address     = a;
    DataIn      = d;
    @(negedge CLK);
    while (Stall && n < 200) begin
      if (MemWrite) begin
        chk({tag, "_addr"}, 32'(MemAddress), 32'(a));
        chk({tag, "_wdata"}, MemDataOut, d);
        chk({tag, "_excl"}, 32'(MemRead), 32'd0);
      end
      n++;
      @(negedge CLK);
    end
    if (exp_stall >= 0) chk({tag, "_stalls"}, 32'(n), 32'(exp_stall));
    else                chk({tag, "_bounded"}, 32'(Stall), 32'd0);
    chk({tag, "_done_strobe"}, 32'(MemWrite), 32'd0);
    @(posedge CLK);
    #1 MemWriteCpu = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = {16'hC0DE, 6'd0, 10'(i)};
      ref_mem[i] = {16'hC0DE, 6'd0, 10'(i)};
    end

    // Reset with a read request pending: outputs must still be quiet.
    MemReadCpu = 1'b1;
    #3;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
    chk("rst_memaddr", 32'(MemAddress), 32'd0);
    chk("rst_dataout", DataOut, 32'd0);
    MemReadCpu = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
`ifdef CACHE_STATS_EN
    chk("rst_hitcount", 32'(HitCount), 32'd0);
`endif

    do_read(10'h000, 5, "cold_miss");
    do_read(10'h003, 0, "read_hit");
    do_write(10'h002, 32'hDEADBEEF, 2, "write_hit");
    chk("write_hit_mem", mem[2], 32'hDEADBEEF);
    do_read(10'h002, 0, "read_after_write");
    do_read(10'h080, 5, "conflict_miss");
    do_read(10'h000, 5, "evicted_miss");
`ifdef CACHE_STATS_EN
    chk("miss_count", 32'(MissCount), 32'd3);
    chk("hit_count", 32'(HitCount), 32'd2);
`endif

    do_write(10'h100, 32'h12345678, 2, "write_miss");
    chk("write_miss_mem", mem[10'h100], 32'h12345678);
    do_read(10'h100, 5, "no_alloc_miss");

    // Variable memory latency.
    ready_rand = 1'b1;
    do_read(10'h1F4, -1, "slow_miss");
    do_write(10'h1F5, 32'hA5A55A5A, -1, "slow_write");
    do_read(10'h1F5, 0, "slow_hit");
    do_read(10'h1F6, 0, "slow_line_hit");
    ready_rand = 1'b0;
    @(posedge CLK);
    #1;

    // Reset in the middle of a fill, after two beats.
    MemReadCpu = 1'b1;
    Address    = 10'h200;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("midfill_stall", 32'(Stall), 32'd0);
    chk("midfill_memread", 32'(MemRead), 32'd0);
    chk("midfill_memaddr", 32'(MemAddress), 32'd0);
`ifdef CACHE_STATS_EN
    chk("midfill_misscount", 32'(MissCount), 32'd0);
`endif
    MemReadCpu = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    do_read(10'h000, 5, "post_reset_miss");
    do_read(10'h001, 0, "post_reset_hit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
